mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency memory between the core's instruction-fetch port and its load/store port. The arbiter grants one requester at a time using round-robin order, registers the granted transaction onto the memory bus, and holds it until the memory acknowledges. It returns read data with a one-cycle valid pulse, and aborts with an error if the memory does not answer within a bounded time. It sits between the CPU's fetch/LSU interfaces and the unified memory, and its per-port stall outputs freeze the PC and writeback.

## Interface
- TIMEOUT, 16: maximum number of cycles mem_req stays high without mem_ready before the transaction aborts; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid only while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_err  out  1  high with if_valid when the fetch timed out.
- if_stall  out  1  combinational: if_req & ~if_valid.
- ls_req  in  1  load/store request; held high with all ls_* inputs stable until ls_valid.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  3  access size code, passed through unchanged.
- ls_addr  in  32  data address.
- ls_wdata  in  32  store data.
- ls_rdata  out  32  load data; 0 for stores and timeouts.
- ls_valid  out  1  one-cycle completion pulse for load/store.
- ls_err  out  1  high with ls_valid when the access timed out.
- ls_stall  out  1  combinational: ls_req & ~ls_valid.
- mem_req, mem_we  out  1  registered memory request and write enable.
- mem_size  out  3  registered size. For a fetch it is 3'd2 (word).
- mem_addr, mem_wdata  out  32  registered address and write data. mem_wdata is 0 for a fetch.
- mem_rdata  in  32  sampled in the cycle where mem_req & mem_ready.
- mem_ready  in  1  memory acknowledge.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - If neither if_req nor ls_req is high, stay in IDLE.
  - Otherwise select a winner:
    - If only one requester is active, it wins.
    - If both are active, the winner is the port not recorded in last_grant.
  - Latch the winner's transaction into the mem_* registers and set mem_req = 1.
  - Record the winner in grant_id and last_grant, clear the timeout counter, and go to BUSY.
- last_grant resets to LS, so the first tie goes to fetch.
- BUSY, with mem_ready = 1:
  - Capture mem_rdata into the winner's rdata register. For a store, capture 0.
  - Clear mem_req, mem_we, mem_addr, mem_wdata, mem_size and err.
  - Go to RESP.
- BUSY, with mem_ready = 0:
  - Increment the counter.
  - If the counter has reached TIMEOUT-1, abort: set rdata = 0, err = 1, clear the mem_* registers, and go to RESP.
  - So mem_req is high for at most TIMEOUT cycles.
- BUSY, with mem_ready high in the same cycle the counter would expire: ready wins and the transaction completes normally.
- RESP:
  - The granted port's valid is high for exactly this cycle; the other port's valid stays 0.
  - Requests are ignored in this cycle. Next state is always IDLE.
- Requester rule: on the edge ending its valid cycle, a requester either drops req or presents a new request. The following IDLE cycle samples that new value.
- A request that is not granted stays pending (stall high) indefinitely. The arbiter never drops it.
- The rdata and err outputs hold their last value outside valid cycles. Consumers must qualify them with valid.

## Timing
- Reset values:
  - mem_req = 0, mem_we = 0, mem_size = 0, mem_addr = 0, mem_wdata = 0.
  - if_valid = ls_valid = 0, if_err = ls_err = 0, if_rdata = ls_rdata = 0.
  - last_grant = LS, counter = 0.
- Reset asserted mid-transaction: mem_req drops asynchronously and the in-flight access is discarded with no valid pulse. A requester still holding req after reset is re-arbitrated from IDLE.
- Latency: if req is first seen in IDLE at cycle T, mem_req is high from T+1. If mem_ready first arrives at cycle T+1+k, valid is high at T+2+k. The minimum is 2 cycles, when ready arrives immediately.
- Back-to-back transactions from one port: each costs at least 3 cycles (IDLE, BUSY, RESP).
- Timeout: valid with err is high at T+1+TIMEOUT.
- The stall outputs are combinational. Every other output is registered.

## Test plan
- Single fetch: if_req at addr 0x10, mem_ready the first cycle with mem_rdata 0x00500093 -> mem_req high for 1 cycle with mem_addr 0x10 and mem_size 2; if_valid for 1 cycle, 2 cycles after the request; if_rdata = 0x00500093, if_err = 0.
- Tie and round-robin: if_req and ls_req held together across repeated transactions -> grants go IF, LS, IF, LS. Each losing port's stall stays high until its valid.
- Store: ls_we = 1, ls_size = 0, addr 0x104, wdata 0xDEADBEEF, mem_ready after 3 cycles -> mem_* carry these values for 4 cycles; ls_valid pulses with ls_rdata = 0 and ls_err = 0.
- Timeout: TIMEOUT = 4, load with mem_ready held at 0 -> mem_req high exactly 4 cycles; then ls_valid = 1, ls_err = 1, ls_rdata = 0. With mem_ready arriving in the 4th cycle instead -> normal completion with err = 0.
- Reset mid-BUSY: reset asserted on the 2nd BUSY cycle -> mem_req = 0 immediately and no valid pulse. After release, the still-held if_req is re-granted with 2-cycle minimum latency.
- Back-to-back loads: ls_req kept high with a new address presented after each valid, mem_ready immediate -> one ls_valid every 3 cycles, each with the correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch
// and load/store ports, with per-transaction timeout and one-cycle completion pulses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  output logic        if_stall,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        ls_err,
  output logic        ls_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {PORT_IF, PORT_LS} port_t;

  state_t     state, stateNext;
  port_t      grantId, lastGrant, winner;
  logic [7:0] count;
  logic       startTxn, finishOk, finishErr;

  assign if_stall = if_req & ~if_valid;
  assign ls_stall = ls_req & ~ls_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startTxn  = 1'b0;
    finishOk  = 1'b0;
    finishErr = 1'b0;
    winner    = PORT_IF;
    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          startTxn  = 1'b1;
          stateNext = BUSY;
          if (if_req && ls_req)
            winner = (lastGrant == PORT_LS) ? PORT_IF : PORT_LS;
          else
            winner = if_req ? PORT_IF : PORT_LS;
        end
      end
      BUSY: begin
        // A late ready still completes normally even on the expiry cycle
        if (mem_ready) begin
          finishOk  = 1'b1;
          stateNext = RESP;
        end else if (count == 8'(TIMEOUT - 1)) begin
          finishErr = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grantId   <= PORT_IF;
      lastGrant <= PORT_LS;
      count     <= '0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_err    <= 1'b0;
      ls_err    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      if (startTxn) begin
        mem_req   <= 1'b1;
        mem_we    <= (winner == PORT_LS) ? ls_we : 1'b0;
        mem_size  <= (winner == PORT_LS) ? ls_size : 3'd2;
        mem_addr  <= (winner == PORT_LS) ? ls_addr : if_addr;
        mem_wdata <= (winner == PORT_LS) ? ls_wdata : '0;
        grantId   <= winner;
        lastGrant <= winner;
        count     <= '0;
      end else if (finishOk || finishErr) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_size  <= '0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        count     <= '0;
        if (grantId == PORT_IF) begin
          if_valid <= 1'b1;
          if_err   <= finishErr;
          if_rdata <= (finishOk && !mem_we) ? mem_rdata : '0;
        end else begin
          ls_valid <= 1'b1;
          ls_err   <= finishErr;
          ls_rdata <= (finishOk && !mem_we) ? mem_rdata : '0;
        end
      end else if (state == BUSY) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        clk, reset;
  logic        if_req, ls_req, ls_we, mem_ready;
  logic [2:0]  ls_size;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_err, if_stall, ls_valid, ls_err, ls_stall, mem_req, mem_we;
  logic [2:0]  mem_size;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .if_err(if_err), .if_stall(if_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_err(ls_err),
    .ls_stall(ls_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ifReq, lsReq, rdy;
    logic [31:0] rdata;
    logic        eMemReq, eIfV, eLsV, eIfS, eLsS;
    logic [31:0] eAddr, eData;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ir, logic lr, logic rd, logic [31:0] rdat,
                              logic emr, logic eiv, logic elv, logic eis, logic els,
                              logic [31:0] ea, logic [31:0] ed);
    vec_t v;
    v.ifReq = ir; v.lsReq = lr; v.rdy = rd; v.rdata = rdat;
    v.eMemReq = emr; v.eIfV = eiv; v.eLsV = elv; v.eIfS = eis; v.eLsS = els;
    v.eAddr = ea; v.eData = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    if_req = 0; ls_req = 0; ls_we = 0; ls_size = 0; mem_ready = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int lastValidCyc;

  // One load/store transaction; readyAt is the 1-based BUSY cycle carrying mem_ready (0 = never)
  task automatic lsTxn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int readyAt,
                       input logic [31:0] rdata, input logic keepReq);
    int   busy;
    bit   done;
    logic expErr;
    int   expBusy;
    expErr  = (readyAt < 1 || readyAt > int'(TO));
    expBusy = expErr ? int'(TO) : readyAt;
    tick;
    ls_req = 1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    mem_ready = 0; mem_rdata = rdata;
    #1;
    chk("ls_idle_memreq", 32'(mem_req), 0);
    chk("ls_idle_stall", 32'(ls_stall), 1);
    busy = 0;
    done = 0;
    for (int i = 0; i < 3 * int'(TO) + 4 && !done; i++) begin
      tick;
      if (mem_req) begin
        busy++;
        chk("ls_mem_we", 32'(mem_we), 32'(we));
        chk("ls_mem_size", 32'(mem_size), 32'(size));
        chk("ls_mem_addr", mem_addr, addr);
        chk("ls_mem_wdata", mem_wdata, wdata);
        mem_ready = (busy == readyAt);
      end else begin
        done = 1;
      end
    end
    chk("ls_txn_bound", 32'(done), 1);
    chk("ls_busy_cycles", 32'(busy), 32'(expBusy));
    #1;
    chk("ls_valid", 32'(ls_valid), 1);
    chk("ls_err", 32'(ls_err), 32'(expErr));
    chk("ls_rdata", ls_rdata, (we || expErr) ? 32'h0 : rdata);
    chk("ls_stall_at_valid", 32'(ls_stall), 0);
    chk("ls_if_valid_quiet", 32'(if_valid), 0);
    chk("ls_mem_addr_cleared", mem_addr, 0);
    lastValidCyc = cyc;
    mem_ready = 0;
    if (!keepReq) ls_req = 0;
  endtask

  // reference-model state for the randomized run
  bit          mActive;
  int          mFree, tS, vCyc;
  logic        mLast, tPort, vPort, vErr, tWe;
  logic [2:0]  tSz;
  logic [31:0] tAd, tWd, vData;
  logic        pIfV, pLsV, eIfV, eLsV, eReq, eWe, eErr;
  logic [2:0]  eSz;
  logic [31:0] eAd, eWd, eD;
  int          v1, v2, v3;

  initial begin
    doReset;
    reset = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_size", 32'(mem_size), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {30'd0, if_valid, ls_valid}, 0);
    chk("rst_errs", {30'd0, if_err, ls_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    doReset;

    // tie round-robin IF, LS, IF, LS then a single fetch
    tbl.push_back(mk(1,1,0,0,            0,0,0,1,1, 0,     0));
    tbl.push_back(mk(1,1,1,32'hA1A1A1A1, 1,0,0,1,1, 32'h10, 0));
    tbl.push_back(mk(1,1,0,0,            0,1,0,0,1, 0,     32'hA1A1A1A1));
    tbl.push_back(mk(1,1,0,0,            0,0,0,1,1, 0,     0));
    tbl.push_back(mk(1,1,1,32'hB2B2B2B2, 1,0,0,1,1, 32'h200, 0));
    tbl.push_back(mk(1,1,0,0,            0,0,1,1,0, 0,     32'hB2B2B2B2));
    tbl.push_back(mk(1,1,0,0,            0,0,0,1,1, 0,     0));
    tbl.push_back(mk(1,1,1,32'hC3C3C3C3, 1,0,0,1,1, 32'h10, 0));
    tbl.push_back(mk(1,1,0,0,            0,1,0,0,1, 0,     32'hC3C3C3C3));
    tbl.push_back(mk(1,1,0,0,            0,0,0,1,1, 0,     0));
    tbl.push_back(mk(1,1,1,32'hD4D4D4D4, 1,0,0,1,1, 32'h200, 0));
    tbl.push_back(mk(1,1,0,0,            0,0,1,1,0, 0,     32'hD4D4D4D4));
    tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,     0));
    tbl.push_back(mk(1,0,0,0,            0,0,0,1,0, 0,     0));
    tbl.push_back(mk(1,0,1,32'h00500093, 1,0,0,1,0, 32'h10, 0));
    tbl.push_back(mk(1,0,0,0,            0,1,0,0,0, 0,     32'h00500093));
    tbl.push_back(mk(0,0,0,0,            0,0,0,0,0, 0,     0));

    if_addr = 32'h10; ls_addr = 32'h200; ls_we = 0; ls_size = 3'd1; ls_wdata = 32'h55;
    foreach (tbl[i]) begin
      tick;
      if_req = tbl[i].ifReq; ls_req = tbl[i].lsReq;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("t%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].eMemReq));
      chk($sformatf("t%0d_mem_addr", i), mem_addr, tbl[i].eAddr);
      chk($sformatf("t%0d_mem_size", i), 32'(mem_size),
          !tbl[i].eMemReq ? 32'd0 : (tbl[i].eAddr == 32'h10) ? 32'd2 : 32'd1);
      chk($sformatf("t%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].eIfV));
      chk($sformatf("t%0d_ls_valid", i), 32'(ls_valid), 32'(tbl[i].eLsV));
      chk($sformatf("t%0d_if_stall", i), 32'(if_stall), 32'(tbl[i].eIfS));
      chk($sformatf("t%0d_ls_stall", i), 32'(ls_stall), 32'(tbl[i].eLsS));
      if (tbl[i].eIfV) begin
        chk($sformatf("t%0d_if_rdata", i), if_rdata, tbl[i].eData);
        chk($sformatf("t%0d_if_err", i), 32'(if_err), 0);
      end
      if (tbl[i].eLsV) begin
        chk($sformatf("t%0d_ls_rdata", i), ls_rdata, tbl[i].eData);
        chk($sformatf("t%0d_ls_err", i), 32'(ls_err), 0);
      end
    end

    // store with ready on 4th BUSY cycle, timeout load, load completing on the expiry cycle
    lsTxn(1, 3'd0, 32'h104, 32'hDEADBEEF, 4, 32'h12345678, 0);
    lsTxn(0, 3'd2, 32'h300, 32'h0, 0, 32'h87654321, 0);
    lsTxn(0, 3'd2, 32'h304, 32'h0, 4, 32'hCAFEF00D, 0);

    // back-to-back loads, immediate ready
    lsTxn(0, 3'd2, 32'h400, 32'h0, 1, 32'h11110000, 1); v1 = lastValidCyc;
    lsTxn(0, 3'd2, 32'h404, 32'h0, 1, 32'h22220000, 1); v2 = lastValidCyc;
    lsTxn(0, 3'd2, 32'h408, 32'h0, 1, 32'h33330000, 0); v3 = lastValidCyc;
    chk("b2b_period_1", 32'(v2 - v1), 3);
    chk("b2b_period_2", 32'(v3 - v2), 3);

    // reset during the second BUSY cycle
    tick;
    if_req = 1; if_addr = 32'h40; mem_ready = 0;
    #1 chk("rb_idle_memreq", 32'(mem_req), 0);
    tick; chk("rb_busy1_memreq", 32'(mem_req), 1);
    tick; chk("rb_busy2_memreq", 32'(mem_req), 1);
    #2 reset = 1;
    #1;
    chk("rb_async_drop", 32'(mem_req), 0);
    chk("rb_no_valid", 32'(if_valid), 0);
    @(posedge clk); #1;
    chk("rb_no_valid_in_reset", 32'(if_valid), 0);
    @(negedge clk) reset = 0;
    #1;
    chk("rb_release_memreq", 32'(mem_req), 0);
    chk("rb_release_stall", 32'(if_stall), 1);
    tick;
    chk("rb_regrant_memreq", 32'(mem_req), 1);
    chk("rb_regrant_addr", mem_addr, 32'h40);
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    tick;
    chk("rb_valid", 32'(if_valid), 1);
    chk("rb_rdata", if_rdata, 32'h0BADF00D);
    chk("rb_err", 32'(if_err), 0);
    if_req = 0; mem_ready = 0;
    tick; chk("rb_valid_pulse_end", 32'(if_valid), 0);

    // randomized run against a transaction-timeline model
    doReset;
    mActive = 0; mFree = 0; vCyc = -1; mLast = 1; pIfV = 0; pLsV = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (pIfV) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (pLsV || (!ls_req && $urandom_range(0, 3) == 0)) begin
        ls_req = pLsV ? 1'($urandom_range(0, 1)) : 1'b1;
        ls_we = 1'($urandom_range(0, 1)); ls_size = 3'($urandom_range(0, 7));
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 9) < 3);
      mem_rdata = $urandom;

      eIfV = (vCyc == c) && (vPort == 0);
      eLsV = (vCyc == c) && (vPort == 1);
      eD = vData; eErr = vErr;
      eReq = 0; eWe = 0; eSz = 0; eAd = 0; eWd = 0;
      if (mActive) begin
        eReq = 1; eWe = tWe; eSz = tSz; eAd = tAd; eWd = tWd;
        if (mem_ready || c == tS + int'(TO)) begin
          vCyc = c + 1; vPort = tPort; vErr = !mem_ready;
          vData = (mem_ready && !tWe) ? mem_rdata : 32'h0;
          mActive = 0; mFree = c + 2;
        end
      end else if (c >= mFree && (if_req || ls_req)) begin
        tPort = (if_req && ls_req) ? !mLast : ls_req;
        tWe = tPort ? ls_we : 1'b0;
        tSz = tPort ? ls_size : 3'd2;
        tAd = tPort ? ls_addr : if_addr;
        tWd = tPort ? ls_wdata : 32'h0;
        mActive = 1; tS = c; mLast = tPort;
      end
      #1;
      chk("r_mem_req", 32'(mem_req), 32'(eReq));
      chk("r_mem_we", 32'(mem_we), 32'(eWe));
      chk("r_mem_size", 32'(mem_size), 32'(eSz));
      chk("r_mem_addr", mem_addr, eAd);
      chk("r_mem_wdata", mem_wdata, eWd);
      chk("r_if_valid", 32'(if_valid), 32'(eIfV));
      chk("r_ls_valid", 32'(ls_valid), 32'(eLsV));
      chk("r_if_stall", 32'(if_stall), 32'(if_req && !eIfV));
      chk("r_ls_stall", 32'(ls_stall), 32'(ls_req && !eLsV));
      if (eIfV) begin
        chk("r_if_rdata", if_rdata, eD);
        chk("r_if_err", 32'(if_err), 32'(eErr));
      end
      if (eLsV) begin
        chk("r_ls_rdata", ls_rdata, eD);
        chk("r_ls_err", 32'(ls_err), 32'(eErr));
      end
      pIfV = eIfV; pLsV = eLsV;
    end
    if_req = 0; ls_req = 0; mem_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
